operand_fetch: RTL and testbench

Operand-fetch stage between instruction decode and execute. Accepts a two-source read request over a valid/ready handshake, drives the read ports of the 32×32 register file, and captures the returned operands. Same-cycle writeback collisions are resolved by bypass. Operands and a pass-through tag are presented to execute over a second valid/ready handshake, at full throughput of one request per cycle.

---
 rtl/operand_fetch_pkg.sv | 16 +
 rtl/operand_skid.sv | 47 ++++
 rtl/operand_fetch.sv | 101 ++++++++++
 tb/tb_operand_fetch.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared operand-fetch types and constants.
// Widths, register count and the decode->fetch request bundle.
package operand_fetch_pkg;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int TW    = 8;
  localparam int NREGS = 32;

  typedef struct packed {
    logic [AW-1:0] ra_a;
    logic [AW-1:0] ra_b;
    logic [TW-1:0] tag;
  } of_req_t;

endpackage

// File: rtl/operand_skid.sv
// S1 hold register plus S2 output register (valid/ready).
// Ports: s1_valid_i/s1_data_i live S1, s1_free_o S1 drains, out_* to execute.
module operand_skid #(
  parameter int W = 72
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s1_valid_i,
  input  logic [W-1:0] s1_data_i,
  output logic         s1_free_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         held_q;
  logic [W-1:0] hold_q;
  logic         s2v_q;
  logic [W-1:0] s2_q;
  logic         s2_free;
  logic [W-1:0] src;

  assign s2_free     = !s2v_q || out_ready_i;
  assign src         = held_q ? hold_q : s1_data_i;
  assign s1_free_o   = s2_free;
  assign out_valid_o = s2v_q;
  assign out_data_o  = s2_q;

  // Read data is only valid for one cycle, so a
  // stalled S1 snapshots it into the hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q <= 1'b0;
      hold_q <= '0;
      s2v_q  <= 1'b0;
      s2_q   <= '0;
    end else if (s2_free) begin
      s2v_q  <= s1_valid_i;
      held_q <= 1'b0;
      if (s1_valid_i) s2_q <= src;
    end else if (s1_valid_i && !held_q) begin
      hold_q <= s1_data_i;
      held_q <= 1'b1;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: RF read, writeback bypass, skid to execute.
// Ports: in_* request, rf_* RF read port, wb_* snoop, out_* operands.
import operand_fetch_pkg::*;

module operand_fetch #(
  parameter int DW = operand_fetch_pkg::DW,
  parameter int AW = operand_fetch_pkg::AW,
  parameter int TW = operand_fetch_pkg::TW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_ra_a,
  input  logic [AW-1:0] in_ra_b,
  input  logic [TW-1:0] in_tag,
  output logic          rf_re_a,
  output logic          rf_re_b,
  output logic [AW-1:0] rf_ra_a,
  output logic [AW-1:0] rf_ra_b,
  input  logic [DW-1:0] rf_out_a,
  input  logic [DW-1:0] rf_out_b,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_wa,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [TW-1:0] out_tag
);

  localparam int W = 2*DW + TW;

  logic          accept;
  logic          s2_free;
  logic          s1_valid_q;
  logic [TW-1:0] s1_tag_q;
  logic          byp_a_q;
  logic          byp_b_q;
  logic [DW-1:0] byp_data_a_q;
  logic [DW-1:0] byp_data_b_q;
  logic [AW-1:0] rf_ra_a_q;
  logic [AW-1:0] rf_ra_b_q;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [W-1:0]  s2_data;

  assign in_ready = rst_n && (!s1_valid_q || s2_free);
  assign accept   = in_valid && in_ready;

  assign rf_re_a = accept;
  assign rf_re_b = accept;
  assign rf_ra_a = accept ? in_ra_a : rf_ra_a_q;
  assign rf_ra_b = accept ? in_ra_b : rf_ra_b_q;

  // RF returns the pre-write value on a collision;
  // the write committed on the accept edge wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_tag_q     <= '0;
      byp_a_q      <= 1'b0;
      byp_b_q      <= 1'b0;
      byp_data_a_q <= '0;
      byp_data_b_q <= '0;
      rf_ra_a_q    <= '0;
      rf_ra_b_q    <= '0;
    end else begin
      s1_valid_q <= accept || (s1_valid_q && !s2_free);
      if (accept) begin
        s1_tag_q     <= in_tag;
        rf_ra_a_q    <= in_ra_a;
        rf_ra_b_q    <= in_ra_b;
        byp_a_q      <= wb_we && (wb_wa == in_ra_a);
        byp_b_q      <= wb_we && (wb_wa == in_ra_b);
        byp_data_a_q <= wb_data;
        byp_data_b_q <= wb_data;
      end
    end
  end

  assign op_a = byp_a_q ? byp_data_a_q : rf_out_a;
  assign op_b = byp_b_q ? byp_data_b_q : rf_out_b;

  operand_skid #(.W(W)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .s1_valid_i  (s1_valid_q),
    .s1_data_i   ({op_a, op_b, s1_tag_q}),
    .s1_free_o   (s2_free),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (s2_data)
  );

  assign out_a   = s2_data[W-1 -: DW];
  assign out_b   = s2_data[DW+TW-1 -: DW];
  assign out_tag = s2_data[TW-1:0];

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized + directed bench for operand_fetch.
// Reference: register array and queue of expected results.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_ra_a = '0;
  logic [AW-1:0] in_ra_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          rf_re_a, rf_re_b;
  logic [AW-1:0] rf_ra_a, rf_ra_b;
  logic [DW-1:0] rf_out_a, rf_out_b;
  logic          wb_we = 1'b0;
  logic [AW-1:0] wb_wa = '0;
  logic [DW-1:0] wb_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_a, out_b;
  logic [TW-1:0] out_tag;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ra_a(in_ra_a), .in_ra_b(in_ra_b),
    .in_tag(in_tag),
    .rf_re_a(rf_re_a), .rf_re_b(rf_re_b),
    .rf_ra_a(rf_ra_a), .rf_ra_b(rf_ra_b),
    .rf_out_a(rf_out_a), .rf_out_b(rf_out_b),
    .wb_we(wb_we), .wb_wa(wb_wa),
    .wb_data(wb_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b),
    .out_tag(out_tag)
  );

  // Register file environment: synchronous read,
  // read returns the value before a same-edge write.
  logic [DW-1:0] rfm [NREGS];
  always @(posedge clk) begin
    if (rf_re_a) rf_out_a <= rfm[rf_ra_a];
    if (rf_re_b) rf_out_b <= rfm[rf_ra_b];
    if (wb_we) rfm[wb_wa] <= wb_data;
  end

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [TW-1:0] tag;
  } res_t;

  logic [DW-1:0] refm [NREGS];
  res_t q[$];
  res_t got_q[$];

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  int hs_cnt = 0;
  logic acc, hs, ov_s;
  logic prev_stall = 1'b0;
  logic [95:0] prev_out;

  task automatic chk(string tg,
                     logic [95:0] got,
                     logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tg, got, exp);
    end
  endtask

  // One clock: sample mid-cycle, update model, advance.
  task automatic cycle();
    res_t e;
    res_t g;
    #3;
    acc  = in_valid && in_ready;
    hs   = out_valid && out_ready;
    ov_s = out_valid;
    if (prev_stall) begin
      chk("stall_valid", 96'(out_valid), 96'd1);
      chk("stall_data",
          96'({out_a, out_b, out_tag}), prev_out);
    end
    if (hs) begin
      hs_cnt++;
      g.a = out_a; g.b = out_b; g.tag = out_tag;
      got_q.push_back(g);
      if (q.size() == 0) begin
        chk("spurious_out", 96'd1, 96'd0);
      end else begin
        e = q.pop_front();
        chk("out_a", 96'(out_a), 96'(e.a));
        chk("out_b", 96'(out_b), 96'(e.b));
        chk("out_tag", 96'(out_tag), 96'(e.tag));
      end
    end
    if (acc) begin
      acc_cnt++;
      e.a = (wb_we && wb_wa == in_ra_a) ?
            wb_data : refm[in_ra_a];
      e.b = (wb_we && wb_wa == in_ra_b) ?
            wb_data : refm[in_ra_b];
      e.tag = in_tag;
      q.push_back(e);
      chk("inflight", 96'(q.size() <= 2), 96'd1);
    end
    if (wb_we) refm[wb_wa] = wb_data;
    prev_stall = out_valid && !out_ready;
    prev_out = 96'({out_a, out_b, out_tag});
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    in_valid = 1'b0;
    wb_we = 1'b1;
    wb_wa = AW'(a);
    wb_data = DW'(d);
    cycle();
    wb_we = 1'b0;
  endtask

  task automatic req(input int a, input int b,
                     input int t);
    in_valid = 1'b1;
    in_ra_a = AW'(a);
    in_ra_b = AW'(b);
    in_tag = TW'(t);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 96'd0, 96'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    wb_we = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      cycle();
    end
    chk("drain", 96'(q.size()), 96'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    #2;
    chk("rst_in_ready", 96'(in_ready), 96'd0);
    chk("rst_out_valid", 96'(out_valid), 96'd0);
    chk("rst_out",
        96'({out_a, out_b, out_tag}), 96'd0);
    chk("rst_rf_re", 96'({rf_re_a, rf_re_b}), 96'd0);
    chk("rst_rf_ra", 96'({rf_ra_a, rf_ra_b}), 96'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NREGS; i++) wr(i, 10 * i);

    // Single read with latency
    out_ready = 1'b1;
    got_q.delete();
    req(5, 6, 'h11);
    cycle();
    chk("lat_t1", 96'(ov_s), 96'd0);
    cycle();
    chk("lat_t2", 96'(ov_s), 96'd1);
    drain();
    chk("single_n", 96'(got_q.size()), 96'd1);
    if (got_q.size() == 1) begin
      chk("single_a", 96'(got_q[0].a), 96'd50);
      chk("single_b", 96'(got_q[0].b), 96'd60);
      chk("single_t", 96'(got_q[0].tag), 96'h11);
    end

    // Streaming, one per cycle
    got_q.delete();
    base = hs_cnt;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_ra_a = AW'(i);
      in_ra_b = AW'(i + 1);
      in_tag = TW'(i);
      cycle();
      chk("stream_acc", 96'(acc), 96'd1);
    end
    in_valid = 1'b0;
    cycle();
    cycle();
    chk("stream_rate", 96'(hs_cnt - base), 96'd32);
    drain();
    if (got_q.size() == 32) begin
      chk("stream_last_a", 96'(got_q[31].a), 96'd310);
      chk("stream_last_b", 96'(got_q[31].b), 96'd0);
    end else begin
      chk("stream_n", 96'(got_q.size()), 96'd32);
    end

    // Collision bypass
    got_q.delete();
    in_valid = 1'b1;
    in_ra_a = 3; in_ra_b = 3; in_tag = 'h21;
    wb_we = 1'b1; wb_wa = 3; wb_data = 'hDEAD;
    cycle();
    chk("coll_acc", 96'(acc), 96'd1);
    in_tag = 'h22;
    wb_data = 'hBEEF;
    cycle();
    wb_we = 1'b0;
    in_tag = 'h23;
    cycle();
    drain();
    if (got_q.size() == 3) begin
      chk("coll0_a", 96'(got_q[0].a), 96'hDEAD);
      chk("coll0_b", 96'(got_q[0].b), 96'hDEAD);
      chk("coll1_a", 96'(got_q[1].a), 96'hBEEF);
      chk("coll2_b", 96'(got_q[2].b), 96'hBEEF);
    end else begin
      chk("coll_n", 96'(got_q.size()), 96'd3);
    end

    // Backpressure
    got_q.delete();
    base = acc_cnt;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_ra_a = AW'($urandom);
      in_ra_b = AW'($urandom);
      in_tag = TW'(8'h40 + i);
      cycle();
    end
    chk("bp_accepts", 96'(acc_cnt - base), 96'd2);
    chk("bp_in_ready", 96'(in_ready), 96'd0);
    drain();
    chk("bp_delivered", 96'(got_q.size()), 96'd2);

    // Reset mid-flight
    out_ready = 1'b1;
    req(7, 8, 'h55);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 96'(out_valid), 96'd0);
    chk("mrst_out",
        96'({out_a, out_b, out_tag}), 96'd0);
    chk("mrst_in_ready", 96'(in_ready), 96'd0);
    chk("mrst_rf_re", 96'({rf_re_a, rf_re_b}), 96'd0);
    q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (ov_s) n++;
    end
    chk("mrst_stale", 96'(n), 96'd0);
    got_q.delete();
    req(0, 31, 'h66);
    drain();
    if (got_q.size() == 1) begin
      chk("mrst_a", 96'(got_q[0].a), 96'd0);
      chk("mrst_b", 96'(got_q[0].b), 96'd310);
    end else begin
      chk("mrst_n", 96'(got_q.size()), 96'd1);
    end

    // Randomized traffic with collisions
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_ra_a = AW'($urandom);
      in_ra_b = AW'($urandom);
      in_tag = TW'($urandom);
      wb_we = $urandom % 2;
      case ($urandom % 3)
        0: wb_wa = in_ra_a;
        1: wb_wa = in_ra_b;
        default: wb_wa = AW'($urandom);
      endcase
      wb_data = $urandom;
      cycle();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
